nibble_sum_accum: RTL and testbench
===================================

// Module: nibble_sum_accum
// PURPOSE
//  Downstream consumer of the 5-bit nibble adder result (ui_in[3:0] + ui_in[7:4]).
//  Accumulates successive sums on debounced-free, synchronised button strobes.
//  Keeps a saturating running total and a sample count, with FULL/SAT status.
//  Drives uo_out/uio_out in the top level; the adder stays combinational upstream.
// PARAMETERS
//  ACC_W      8   accumulator width (bits); total saturates at 2**ACC_W-1
//  CNT_W      4   sample-counter width (bits)
//  MAX_COUNT  15  samples accepted before FULL; must be >=1 and <= 2**CNT_W-1
// PORTS
//  clk        in   1      clock
//  rst_n      in   1      asynchronous active-low reset
//  ena        in   1      design enable; strobes ignored while low
//  sum_in     in   5      adder result, 0..30, combinational from upstream
//  add_raw    in   1      asynchronous "add" request pin, level
//  clr_raw    in   1      asynchronous "clear" request pin, level
//  acc_out    out  ACC_W  running total
//  count_out  out  CNT_W  number of accepted samples
//  full       out  1      high when count_out == MAX_COUNT
//  sat        out  1      sticky: a sample was clipped at saturation
// BEHAVIOUR
//  Reset (rst_n low, async): acc_out=0, count_out=0, full=0, sat=0, all sync flops=0,
//   state=IDLE. Reset mid-operation discards the total and all in-flight strobes.
//  Sync: each raw pin passes through 2 flops (s1,s2) plus history flop s3;
//   pulse = s2 & ~s3 (one cycle per rising edge; holding the pin high gives one pulse).
//   Raw pin high at edge N -> pulse high during cycle after edge N+1 -> registers
//   update at edge N+2. Synchronisers run regardless of ena.
//  Pulses acted on only when ena=1; otherwise dropped (not queued).
//  sum_in sampled at the same edge that acts on add pulse (no extra latency).
//  FSM states: IDLE (count=0), ACCUM (0<count<MAX_COUNT), FULL (count=MAX_COUNT).
//   IDLE  --add--> ACCUM (or FULL if MAX_COUNT==1)
//   ACCUM --add--> ACCUM, or FULL when count reaches MAX_COUNT
//   FULL  --add--> FULL, ignored: acc/count unchanged, sat unchanged
//   any   --clr--> IDLE: acc=0, count=0, sat=0
//  Clear and add pulses in same cycle: clear wins, add is dropped.
//  Arithmetic: next = acc + zero-extended sum_in, computed at ACC_W+1 bits;
//   if next > 2**ACC_W-1: acc = 2**ACC_W-1, sat=1; else acc = next.
//  Once saturated, further adds keep acc at max and count still increments.
//  sum_in=0 add is a valid sample: count increments, acc unchanged.
//  full is a registered decode of state==FULL; all outputs registered, no comb paths
//   from inputs to outputs.
// TESTING
//  1 Reset: assert rst_n=0 mid-accumulation (acc=42) -> all outputs 0 immediately,
//    no clock needed.
//  2 Latency: sum_in=7, add_raw 0->1 held 10 cycles -> acc_out=7, count_out=1
//    exactly 2 edges after first sampled high; no second increment while held.
//  3 Saturation: sum_in=30, 9 add strobes -> after 8: acc=240, sat=0;
//    after 9th: acc=255, sat=1, count=9.
//  4 Full: sum_in=1, 15 strobes -> acc=15, count=15, full=1; 16th strobe ->
//    acc=15, count=15 unchanged.
//  5 Priority: add_raw and clr_raw rise same cycle with acc=20 -> acc=0, count=0,
//    sat=0, state IDLE; next add with sum_in=3 -> acc=3.
//  6 Enable: ena=0, three add strobes with sum_in=5 -> acc/count unchanged;
//    ena=1 then one strobe -> acc=5, count=1.

Source files
------------

// File: rtl/nibble_sum_accum.sv
// Saturating accumulator for the nibble-adder result.
// Synchronised add/clear strobes, sample counter, FULL and sticky SAT status.
module nibble_sum_accum #(
  parameter int ACC_W     = 8,
  parameter int CNT_W     = 4,
  parameter int MAX_COUNT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [4:0]       sum_in,
  input  logic             add_raw,
  input  logic             clr_raw,
  output logic [ACC_W-1:0] acc_out,
  output logic [CNT_W-1:0] count_out,
  output logic             full,
  output logic             sat
);

  // state | meaning
  // IDLE  | no samples accepted, count == 0
  // ACCUM | 0 < count < MAX_COUNT
  // FULL  | count == MAX_COUNT, further adds ignored

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_COUNT);

  state_t state, state_nxt;

  logic [2:0] add_sync, clr_sync;
  logic       add_pulse, clr_pulse;
  logic       add_act, clr_act;

  logic [ACC_W:0]   acc_sum;
  logic [CNT_W-1:0] count_inc;

  logic [ACC_W-1:0] acc_d;
  logic [CNT_W-1:0] count_d;
  logic             sat_d;
  logic             full_d;

  // Bit 0 = s1, bit 1 = s2, bit 2 = edge-history flop s3.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_sync <= 3'b000;
      clr_sync <= 3'b000;
    end else begin
      add_sync <= {add_sync[1:0], add_raw};
      clr_sync <= {clr_sync[1:0], clr_raw};
    end
  end

  assign add_pulse = add_sync[1] & ~add_sync[2];
  assign clr_pulse = clr_sync[1] & ~clr_sync[2];

  // Clear takes priority; a coincident add is dropped rather than deferred.
  assign clr_act = ena & clr_pulse;
  assign add_act = ena & add_pulse & ~clr_pulse;

  assign acc_sum   = {1'b0, acc_out} + {{(ACC_W-4){1'b0}}, sum_in};
  assign count_inc = count_out + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc_out   <= '0;
      count_out <= '0;
      sat       <= 1'b0;
      full      <= 1'b0;
    end else begin
      state     <= state_nxt;
      acc_out   <= acc_d;
      count_out <= count_d;
      sat       <= sat_d;
      full      <= full_d;
    end
  end

  always_comb begin
    state_nxt = state;
    if (clr_act) begin
      state_nxt = IDLE;
    end else if (add_act) begin
      case (state)
        IDLE:    state_nxt = (CNT_MAX == 1) ? FULL : ACCUM;
        ACCUM:   state_nxt = (count_inc == CNT_MAX) ? FULL : ACCUM;
        FULL:    state_nxt = FULL;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    acc_d   = acc_out;
    count_d = count_out;
    sat_d   = sat;
    if (clr_act) begin
      acc_d   = '0;
      count_d = '0;
      sat_d   = 1'b0;
    end else if (add_act && state != FULL) begin
      count_d = count_inc;
      if (acc_sum > {1'b0, ACC_MAX}) begin
        acc_d = ACC_MAX;
        sat_d = 1'b1;
      end else begin
        acc_d = acc_sum[ACC_W-1:0];
      end
    end
    full_d = (state_nxt == FULL);
  end

endmodule

// File: tb/tb_nibble_sum_accum.sv
// Directed bench for nibble_sum_accum with hand-computed expectations.
module tb_nibble_sum_accum;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [4:0] sum_in;
  logic       add_raw;
  logic       clr_raw;
  logic [7:0] acc_out;
  logic [3:0] count_out;
  logic       full;
  logic       sat;

  int n_cmp;
  int n_fail;

  nibble_sum_accum #(.ACC_W(8), .CNT_W(4), .MAX_COUNT(15)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .sum_in    (sum_in),
    .add_raw   (add_raw),
    .clr_raw   (clr_raw),
    .acc_out   (acc_out),
    .count_out (count_out),
    .full      (full),
    .sat       (sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic check_all(input string tag, input int e_acc, input int e_cnt,
                           input int e_full, input int e_sat);
    check({tag, ".acc"},   int'(acc_out),   e_acc);
    check({tag, ".count"}, int'(count_out), e_cnt);
    check({tag, ".full"},  int'(full),      e_full);
    check({tag, ".sat"},   int'(sat),       e_sat);
  endtask

  // Raise selected pins for 3 cycles, drop them, then let the pulse settle.
  task automatic strobe(input bit do_add, input bit do_clr);
    @(negedge clk);
    add_raw = do_add;
    clr_raw = do_clr;
    repeat (3) @(negedge clk);
    add_raw = 1'b0;
    clr_raw = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    n_cmp   = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    ena     = 1'b1;
    sum_in  = 5'd0;
    add_raw = 1'b0;
    clr_raw = 1'b0;
    repeat (2) @(negedge clk);
    check_all("reset_init", 0, 0, 0, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Async reset mid-accumulation
    sum_in = 5'd21;
    strobe(1'b1, 1'b0);
    strobe(1'b1, 1'b0);
    check_all("pre_reset", 42, 2, 0, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_all("async_reset", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Latency: update lands exactly two edges after the first sampling edge
    @(negedge clk);
    sum_in  = 5'd7;
    add_raw = 1'b1;
    @(posedge clk); #1 check("lat_edgeN.acc", int'(acc_out), 0);
    @(posedge clk); #1 check("lat_edgeN1.acc", int'(acc_out), 0);
    @(posedge clk); #1 check_all("lat_edgeN2", 7, 1, 0, 0);
    repeat (8) @(negedge clk);
    add_raw = 1'b0;
    repeat (3) @(negedge clk);
    check_all("lat_held", 7, 1, 0, 0);

    // Zero-valued sample still counts
    sum_in = 5'd0;
    strobe(1'b1, 1'b0);
    check_all("zero_sample", 7, 2, 0, 0);

    // Saturation
    strobe(1'b0, 1'b1);
    check_all("clear1", 0, 0, 0, 0);
    sum_in = 5'd30;
    for (int i = 0; i < 8; i++) strobe(1'b1, 1'b0);
    check_all("sat_8", 240, 8, 0, 0);
    strobe(1'b1, 1'b0);
    check_all("sat_9", 255, 9, 0, 1);
    strobe(1'b1, 1'b0);
    check_all("sat_10", 255, 10, 0, 1);

    // Full
    strobe(1'b0, 1'b1);
    check_all("clear2", 0, 0, 0, 0);
    sum_in = 5'd1;
    for (int i = 0; i < 14; i++) strobe(1'b1, 1'b0);
    check_all("full_14", 14, 14, 0, 0);
    strobe(1'b1, 1'b0);
    check_all("full_15", 15, 15, 1, 0);
    strobe(1'b1, 1'b0);
    check_all("full_16", 15, 15, 1, 0);

    // Clear beats a coincident add
    strobe(1'b0, 1'b1);
    sum_in = 5'd20;
    strobe(1'b1, 1'b0);
    check_all("prio_pre", 20, 1, 0, 0);
    strobe(1'b1, 1'b1);
    check_all("prio_both", 0, 0, 0, 0);
    sum_in = 5'd3;
    strobe(1'b1, 1'b0);
    check_all("prio_after", 3, 1, 0, 0);

    // Enable gating
    strobe(1'b0, 1'b1);
    ena    = 1'b0;
    sum_in = 5'd5;
    for (int i = 0; i < 3; i++) strobe(1'b1, 1'b0);
    check_all("ena_off", 0, 0, 0, 0);
    ena = 1'b1;
    strobe(1'b1, 1'b0);
    check_all("ena_on", 5, 1, 0, 0);
    ena = 1'b0;
    strobe(1'b0, 1'b1);
    check_all("ena_off_clr", 5, 1, 0, 0);
    ena = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
